trace_collector: RTL and testbench
==================================

# trace_collector

Consumer side of the trace filter: captures every retired instruction that the filter does not drop, together with its PC, into a FIFO. It streams the captured items to the host DMA over an AXI-Stream-style valid/ready master port. Items are grouped into fixed-length packets delimited by `m_tlast`. A flush request closes a partial packet.

## Interface
Parameters:
- `FIFO_DEPTH`, 16 — item buffer entries; power of two, ≥ 4.
- `PACKET_LEN`, 8 — items per packet; 1..256.
- `PC_WIDTH`, 64 — PC field width.

Ports:
- `clk`  in  1  — sole clock, rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `en`  in  1  — capture enable; sampled each cycle.
- `flush`  in  1  — one-cycle pulse; close the current packet and drain.
- `instr_valid`  in  1  — `pc`/`instr` hold a retired instruction this cycle.
- `pc`  in  PC_WIDTH  — PC of the retired instruction.
- `instr`  in  32  — instruction word.
- `drop_instr`  in  1  — filter verdict for `instr`; 1 = discard.
- `m_tdata`  out  PC_WIDTH+32  — item, `{pc, instr}`.
- `m_tvalid`  out  1  — item valid.
- `m_tready`  in  1  — sink accepts.
- `m_tlast`  out  1  — last item of the packet.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  — occupied entries.
- `overflow`  out  1  — sticky; at least one kept item was lost.
- `busy`  out  1  — state ≠ IDLE or FIFO not empty.

## Operation
- Capture condition: `push = instr_valid & en & ~drop_instr & (state != FLUSH)`.
- When FIFO is full and no pop occurs in the same cycle:
  - the pushed item is discarded;
  - `overflow` is set.
- `overflow` is cleared only by reset or on FLUSH→IDLE exit.
- Pop condition: `m_tvalid & m_tready`.
- `pkt_cnt` counts pops within the current packet, width $clog2(PACKET_LEN)+1:
  - increments on each pop;
  - resets to 0 on a pop carrying `m_tlast`.
- `m_tlast` = (`pkt_cnt == PACKET_LEN-1`) OR (state == FLUSH AND `fifo_level == 1`).
- State machine:
  - IDLE→RUN when `en`=1.
  - RUN→IDLE when `en`=0 and the FIFO is empty.
  - IDLE or RUN → FLUSH on `flush`=1, if the FIFO is non-empty.
  - FLUSH→IDLE after the pop that empties the FIFO; `pkt_cnt` is cleared.
  - `flush` with an empty FIFO: no state change, no packet emitted, `pkt_cnt` cleared.
- `flush` pulses are ignored while in FLUSH.
- Deasserting `en` does not discard buffered items. They keep draining, and packet boundaries follow `PACKET_LEN` only.

## Timing
- Reset values:
  - `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0;
  - `fifo_level`=0, `overflow`=0, `busy`=0;
  - state = IDLE, `pkt_cnt`=0.
- Latency: an item pushed in cycle N has `m_tvalid`=1 in cycle N+1 at the earliest (registered FIFO output).
- While `m_tvalid`=1 and `m_tready`=0, `m_tdata` and `m_tlast` are held stable.
- Throughput is one item per cycle when `m_tready`=1.
- Simultaneous push and pop:
  - level is unchanged;
  - a push into a full FIFO succeeds if a pop occurs in the same cycle.
- Pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by the level counter, not by pointer equality.
- Reset asserted mid-packet drops all contents immediately. Outputs take their reset values asynchronously.
- `fifo_level` and `overflow` update at the edge following the push or pop.

## Configuration
- `TRACE_COLLECTOR_LOST_COUNT_EN` defined:
  - adds output `lost_count` [31:0], which counts discarded-on-full items;
  - saturates at 32'hFFFFFFFF;
  - cleared under the same conditions as `overflow`.
- Undefined: the port and counter are absent; only sticky `overflow` reports loss.

## Structure
- Shared package `trace_pkg`:
  - `trace_item_t` packed struct {pc, instr};
  - state enum `collector_state_t` {IDLE, RUN, FLUSH};
  - the branch/jump opcode constants shared with the filter.
- Sub-module `trace_fifo`: synchronous FIFO with first-word-fall-through registered output and a level output, parameterised by width and depth. Packet counting, the FSM and loss accounting stay in `trace_collector`.

## Test plan
- Reset, `en`=1, 8 kept items with `m_tready`=1 → 8 beats on consecutive cycles. First beat appears 1 cycle after first push; `m_tlast`=1 only on beat 8.
- Alternating `drop_instr`=1/0 over 6 valid cycles → exactly 3 beats, matching the kept `{pc, instr}` in order.
- `m_tready`=0, push 18 items with FIFO_DEPTH=16 → `fifo_level`=16 and `overflow`=1. With the macro, `lost_count`=2. Releasing `m_tready` yields the first 16 items only.
- 3 items buffered, then `flush` pulse → 3 beats with `m_tlast` on the third, state returns to IDLE, `overflow` cleared. The next 8 items form a full packet.
- `flush` with empty FIFO → no beat, `busy` stays 0, next packet still 8 items long.
- FIFO full with `m_tready`=1 and a push in the same cycle → item accepted, level stays 16, `overflow` stays 0. Then assert `rst_n`=0 mid-stream → `m_tvalid`=0 immediately, `fifo_level`=0.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared trace types: item layout, collector FSM states, control-transfer opcodes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package trace_pkg;

  localparam int TRACE_PC_W = 64;

  // One captured trace item as it leaves the collector: {pc, instr}.
  typedef struct packed {
    logic [TRACE_PC_W-1:0] pc;
    logic [31:0]           instr;
  } trace_item_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } collector_state_t;

  // Branch/jump major opcodes, shared with the trace filter.
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  function automatic logic is_cti(input logic [31:0] ins);
    return (ins[6:0] == OPC_BRANCH) || (ins[6:0] == OPC_JAL) || (ins[6:0] == OPC_JALR);
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy level.
// Latency: a word written at edge N is visible on dat_o/vld_o in cycle N+1.
// Backpressure: writes into a full FIFO are dropped unless a read happens in the same cycle.
//
// Ports: push_i/push_dat_i write side; pop_i read side (ignored when empty);
//        dat_o/vld_o head of queue (dat_o is 0 when empty); full_o; level_o occupancy.
module trace_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dat_o,
  output logic                     vld_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             wr_en, rd_en;

  assign vld_o   = (level_q != '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign level_o = level_q;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en   = push_i & (~full_o | pop_i);
  assign rd_en   = pop_i & vld_o;
  // Gate the head so the output reads 0 while empty (incl. right after reset).
  assign dat_o   = vld_o ? mem_q[rd_ptr_q] : '0;

  // Storage needs no reset: it is only observed through level_q.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_dat_i;
  end

  // Pointers wrap naturally (DEPTH is a power of two); level tells full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/trace_collector.sv
// Captures kept retired instructions {pc, instr} and streams them as fixed-length packets.
// Latency: an item captured at edge N is offered on m_tvalid in cycle N+1; one beat/cycle.
// Backpressure: m_tready=0 holds m_tdata/m_tlast; kept items arriving at a full FIFO are lost (overflow).
//
// Ports: en capture enable; flush closes the current packet; instr_valid/pc/instr/drop_instr
//        from the filter; m_tdata/m_tvalid/m_tready/m_tlast stream master; fifo_level,
//        overflow (sticky loss flag), busy status.
// Optional: TRACE_COLLECTOR_LOST_COUNT_EN adds lost_count, a saturating count of lost items.
module trace_collector
  import trace_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int PACKET_LEN = 8,
  parameter int PC_WIDTH   = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          flush,
  input  logic                          instr_valid,
  input  logic [PC_WIDTH-1:0]           pc,
  input  logic [31:0]                   instr,
  input  logic                          drop_instr,
  output logic [PC_WIDTH+31:0]          m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          busy
`ifdef TRACE_COLLECTOR_LOST_COUNT_EN
  ,
  output logic [31:0]                   lost_count
`endif
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(PACKET_LEN) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(PACKET_LEN - 1);
  localparam logic [LW-1:0] ONE_LEFT = LW'(1);

  collector_state_t state_q, state_d;
  logic [CW-1:0]    pkt_cnt_q, pkt_cnt_d;
  logic             overflow_q, overflow_d;
  logic             push, pop, fifo_full, fifo_empty, lost, flush_exit, flush_empty;

  assign push        = instr_valid & en & ~drop_instr & (state_q != FLUSH);
  assign pop         = m_tvalid & m_tready;
  assign fifo_empty  = (fifo_level == '0);
  assign lost        = push & fifo_full & ~pop;
  // Leaving FLUSH: the pop that takes the final buffered item.
  assign flush_exit  = (state_q == FLUSH) & pop & (fifo_level == ONE_LEFT);
  // Flush with nothing buffered only realigns the packet counter.
  assign flush_empty = flush & (state_q != FLUSH) & fifo_empty;

  trace_fifo #(
    .WIDTH (PC_WIDTH + 32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_dat_i ({pc, instr}),
    .pop_i      (pop),
    .dat_o      (m_tdata),
    .vld_o      (m_tvalid),
    .full_o     (fifo_full),
    .level_o    (fifo_level)
  );

  // Gated by m_tvalid so nothing is flagged while there is no beat.
  assign m_tlast  = m_tvalid & ((pkt_cnt_q == LAST_IDX) |
                                ((state_q == FLUSH) & (fifo_level == ONE_LEFT)));
  assign overflow = overflow_q;
  assign busy     = (state_q != IDLE) | ~fifo_empty;

  always_comb begin
    state_d    = state_q;
    pkt_cnt_d  = pkt_cnt_q;
    overflow_d = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (flush && !fifo_empty) state_d = FLUSH;
        else if (en)              state_d = RUN;
      end
      RUN: begin
        if (flush && !fifo_empty)   state_d = FLUSH;
        else if (!en && fifo_empty) state_d = IDLE;
      end
      FLUSH: begin
        if (flush_exit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (pop)         pkt_cnt_d = m_tlast ? '0 : pkt_cnt_q + CW'(1);
    if (flush_empty || flush_exit) pkt_cnt_d = '0;

    if (lost)       overflow_d = 1'b1;
    if (flush_exit) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pkt_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pkt_cnt_q  <= pkt_cnt_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef TRACE_COLLECTOR_LOST_COUNT_EN
  logic [31:0] lost_q, lost_d;

  always_comb begin
    lost_d = lost_q;
    if (lost && lost_q != 32'hFFFF_FFFF) lost_d = lost_q + 32'd1;
    if (flush_exit)                      lost_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lost_q <= '0;
    else        lost_q <= lost_d;
  end

  assign lost_count = lost_q;
`endif

endmodule

// File: tb/tb_trace_collector.sv
// Directed scoreboard bench for trace_collector (FIFO_DEPTH=16, PACKET_LEN=8, PC_WIDTH=64).
module tb_trace_collector;

  logic        clk;
  logic        rst_n;
  logic        en, flush, instr_valid, drop_instr, m_tready;
  logic [63:0] pc;
  logic [31:0] instr;
  logic [95:0] m_tdata;
  logic        m_tvalid, m_tlast, overflow, busy;
  logic [4:0]  fifo_level;
`ifdef TRACE_COLLECTOR_LOST_COUNT_EN
  logic [31:0] lost_count;
`endif

  trace_collector #(.FIFO_DEPTH(16), .PACKET_LEN(8), .PC_WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
    .instr_valid(instr_valid), .pc(pc), .instr(instr), .drop_instr(drop_instr),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .fifo_level(fifo_level), .overflow(overflow), .busy(busy)
`ifdef TRACE_COLLECTOR_LOST_COUNT_EN
    , .lost_count(lost_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        last;
    logic [95:0] dat;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   beats = 0;
  int   first_cyc = 0;
  int   last_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every accepted beat must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst_n && m_tvalid && m_tready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL beat: unexpected beat dat=%h last=%0d, none required", m_tdata, m_tlast);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (m_tdata !== e.dat || m_tlast !== e.last) begin
          n_bad++;
          $display("FAIL beat: got dat=%h last=%0d, required dat=%h last=%0d",
                   m_tdata, m_tlast, e.dat, e.last);
        end
      end
      if (beats == 0) first_cyc = cyc;
      last_cyc = cyc;
      beats++;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  function automatic logic [63:0] ipc(input int i);
    return 64'h8000_0000 + 64'(i) * 64'd4;
  endfunction

  function automatic logic [31:0] iins(input int i);
    return 32'h0000_0013 | (32'(i) << 20);
  endfunction

  task automatic expect_item(input int i, input logic last);
    exp_t e;
    e.last = last;
    e.dat  = {ipc(i), iins(i)};
    exp_q.push_back(e);
  endtask

  // Present one instruction for exactly one cycle; returns 1 time unit after the edge.
  task automatic drv(input int i, input logic drop);
    instr_valid = 1'b1;
    pc          = ipc(i);
    instr       = iins(i);
    drop_instr  = drop;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    drop_instr  = 1'b0;
  endtask

  task automatic wait_drain(input string nm, input int max);
    int k = 0;
    while (exp_q.size() != 0 && k < max) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk(nm, 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    int push_cyc;
    rst_n = 1'b0; en = 1'b0; flush = 1'b0; instr_valid = 1'b0;
    drop_instr = 1'b0; m_tready = 1'b0; pc = '0; instr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 128'(m_tvalid), 128'(0));
    chk("rst_tlast",  128'(m_tlast),  128'(0));
    chk("rst_tdata",  128'(m_tdata),  128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_level",    128'(fifo_level), 128'(0));
    chk("rst_overflow", 128'(overflow),   128'(0));
    chk("rst_busy",     128'(busy),       128'(0));

    // A: 8 kept items, sink always ready -> one full packet, back-to-back.
    en = 1'b1; m_tready = 1'b1; beats = 0;
    push_cyc = cyc;
    chk("a_pre_tvalid", 128'(m_tvalid), 128'(0));
    for (int i = 0; i < 8; i++) begin
      expect_item(i, i == 7);
      drv(i, 1'b0);
      if (i == 0) chk("a_first_tvalid", 128'(m_tvalid), 128'(1));
    end
    wait_drain("a_drain", 20);
    chk("a_beats",   128'(beats), 128'(8));
    chk("a_latency", 128'(first_cyc - push_cyc), 128'(1));
    chk("a_b2b",     128'(last_cyc - first_cyc), 128'(7));

    // B: alternating drop over 6 valid cycles -> only items 101,103,105 stream.
    beats = 0;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 1) expect_item(100 + k, 1'b0);
      drv(100 + k, (k % 2 == 0));
    end
    wait_drain("b_drain", 20);
    chk("b_beats", 128'(beats), 128'(3));

    // E: flush with an empty FIFO while idle -> no beat, busy low, packet counter realigned.
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("e_busy_pre", 128'(busy), 128'(0));
    beats = 0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("e_busy_post", 128'(busy),  128'(0));
    chk("e_beats",     128'(beats), 128'(0));

    // C: sink stalled, 18 pushes into 16 entries -> 2 lost, first 16 stream as two packets.
    en = 1'b1; m_tready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) expect_item(200 + i, (i == 7) || (i == 15));
      drv(200 + i, 1'b0);
    end
    chk("c_level",    128'(fifo_level), 128'(16));
    chk("c_overflow", 128'(overflow),   128'(1));
`ifdef TRACE_COLLECTOR_LOST_COUNT_EN
    chk("c_lost", 128'(lost_count), 128'(2));
`endif
    m_tready = 1'b1;
    wait_drain("c_drain", 40);
    chk("c_overflow_sticky", 128'(overflow), 128'(1));

    // D: 3 items buffered, flush -> 3 beats closed early, overflow cleared, then full packet.
    m_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_item(400 + i, i == 2);
      drv(400 + i, 1'b0);
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    m_tready = 1'b1;
    wait_drain("d_flush_drain", 20);
    chk("d_idle_busy", 128'(busy),     128'(0));
    chk("d_overflow",  128'(overflow), 128'(0));
`ifdef TRACE_COLLECTOR_LOST_COUNT_EN
    chk("d_lost", 128'(lost_count), 128'(0));
`endif
    for (int i = 0; i < 8; i++) begin
      expect_item(500 + i, i == 7);
      drv(500 + i, 1'b0);
    end
    wait_drain("d_pkt_drain", 20);

    // F: full FIFO, pop and push in the same cycle -> push accepted, level holds at 16.
    m_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      expect_item(300 + i, (i == 7) || (i == 15));
      drv(300 + i, 1'b0);
    end
    chk("f_full_level", 128'(fifo_level), 128'(16));
    m_tready = 1'b1;
    expect_item(316, 1'b0);
    drv(316, 1'b0);
    m_tready = 1'b0;
    chk("f_same_level",    128'(fifo_level), 128'(16));
    chk("f_same_overflow", 128'(overflow),   128'(0));
    chk("f_head_after",    128'(m_tdata),    128'({ipc(301), iins(301)}));

    // Reset mid-stream: outputs clear asynchronously, before any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_tvalid", 128'(m_tvalid),   128'(0));
    chk("r_level",  128'(fifo_level), 128'(0));
    chk("r_tlast",  128'(m_tlast),    128'(0));
    chk("r_tdata",  128'(m_tdata),    128'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    en = 1'b0;
    @(posedge clk); #1;
    chk("r_busy",     128'(busy),     128'(0));
    chk("r_overflow", 128'(overflow), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
